tt_operand_loader: RTL and testbench

//   Upstream input stage for the tt_um top-level adder datapath.

---
 rtl/tt_operand_loader.sv | 154 +++++++++++++++
 tb/tb_tt_operand_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_operand_loader.sv
// tt_operand_loader: front end of the tt_um adder datapath.
// Synchronizes the pad-driven strobe, clear and data bus, debounces the strobe,
// and collects two strobed bytes into an operand pair that is offered downstream
// with a valid/ready handshake.
module tt_operand_loader #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             strobe_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    VALID  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0]            strobe_sync;
  logic [SYNC_STAGES-1:0]            clear_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] data_sync;

  logic             strobe_s;
  logic             clear_s;
  logic [WIDTH-1:0] data_s;

  logic [CNT_W-1:0] deb_cnt;
  logic             deb_level;
  logic             deb_level_prev;
  logic             strobe_evt;

  logic [WIDTH-1:0] op_a_next;
  logic [WIDTH-1:0] op_b_next;
  logic             op_valid_next;
  logic             overrun_next;

  assign strobe_s   = strobe_sync[SYNC_STAGES-1];
  assign clear_s    = clear_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign strobe_evt = deb_level & ~deb_level_prev;

  // Synchronizer chains: shift each pad input through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      clear_sync  <= '0;
      data_sync   <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], strobe_in};
      clear_sync  <= {clear_sync[SYNC_STAGES-2:0], clear_in};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], data_in};
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt        <= '0;
      deb_level      <= 1'b0;
      deb_level_prev <= 1'b0;
    end else begin
      deb_level_prev <= deb_level;
      if (strobe_s == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_cnt   <= '0;
        deb_level <= ~deb_level;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // FSM state register plus registered outputs; busy is derived from the next state
  // so that it is a flop that always matches the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      op_a     <= op_a_next;
      op_b     <= op_b_next;
      op_valid <= op_valid_next;
      overrun  <= overrun_next;
      busy     <= (state_next != IDLE);
    end
  end

  // Next-state logic: clear dominates, then capture/handshake per state.
  always_comb begin
    state_next    = state;
    op_a_next     = op_a;
    op_b_next     = op_b;
    op_valid_next = op_valid;
    overrun_next  = overrun;
    if (clear_s) begin
      state_next    = IDLE;
      op_valid_next = 1'b0;
      overrun_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_evt) begin
            op_a_next  = data_s;
            state_next = HAVE_A;
          end
        end
        HAVE_A: begin
          if (strobe_evt) begin
            op_b_next     = data_s;
            op_valid_next = 1'b1;
            state_next    = VALID;
          end
        end
        VALID: begin
          // A strobe while the pair is still owned here is dropped, even if the
          // pair is being consumed in the same cycle.
          if (op_valid && op_ready) begin
            op_valid_next = 1'b0;
            state_next    = IDLE;
          end
          if (strobe_evt) begin
            overrun_next = 1'b1;
          end
        end
        default: begin
          state_next    = IDLE;
          op_valid_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_operand_loader.sv
// Testbench for tt_operand_loader: directed scenarios followed by a randomized
// sequence of strobes, glitches, handshakes and clears checked against a
// transaction-level model of the operand pair.
module tb_tt_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       strobe_in;
  logic       clear_in;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_valid;
  logic       op_ready;
  logic       busy;
  logic       overrun;

  int n_compared;
  int n_mismatched;

  // Transaction-level model: how many operands are held (0, 1, 2 = pair pending).
  int         m_held;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_ovr;

  tt_operand_loader #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .strobe_in(strobe_in),
    .clear_in(clear_in),
    .op_a(op_a),
    .op_b(op_b),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_pulse(input logic [7:0] d, input int hi, input int lo);
    data_in   = d;
    strobe_in = 1'b1;
    tick(hi);
    strobe_in = 1'b0;
    tick(lo);
  endtask

  task automatic model_strobe(input logic [7:0] d);
    if (m_held == 0) begin
      m_a    = d;
      m_held = 1;
    end else if (m_held == 1) begin
      m_b    = d;
      m_held = 2;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    data_in      = 8'h00;
    strobe_in    = 1'b0;
    clear_in     = 1'b0;
    op_ready     = 1'b0;
    tick(3);
    check("reset_op_a", op_a, 8'h00);
    check("reset_op_b", op_b, 8'h00);
    check("reset_valid", op_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Basic load with downstream always ready; measure op_valid latency.
    op_ready = 1'b1;
    strobe_pulse(8'h12, 10, 10);
    check("load_a_busy", busy, 1'b1);
    check("load_a_op_a", op_a, 8'h12);
    check("load_a_valid", op_valid, 1'b0);
    data_in   = 8'h34;
    strobe_in = 1'b1;
    tick(6);
    check("lat_before_edge6", op_valid, 1'b0);
    tick(1);
    check("lat_at_edge6", op_valid, 1'b1);
    check("pair_op_a", op_a, 8'h12);
    check("pair_op_b", op_b, 8'h34);
    tick(1);
    check("valid_one_cycle", op_valid, 1'b0);
    check("idle_after_hs", busy, 1'b0);
    tick(2);
    strobe_in = 1'b0;
    tick(10);
    check("no_extra_valid", op_valid, 1'b0);

    // Glitch filter: short pulse and 1-on/1-off bouncing.
    strobe_pulse(8'h77, 3, 10);
    check("glitch3_busy", busy, 1'b0);
    check("glitch3_op_a", op_a, 8'h12);
    data_in = 8'h66;
    for (int i = 0; i < 10; i++) begin
      strobe_in = 1'b1;
      tick(1);
      strobe_in = 1'b0;
      tick(1);
    end
    tick(10);
    check("bounce_busy", busy, 1'b0);
    check("bounce_op_a", op_a, 8'h12);

    // Backpressure and overrun.
    op_ready = 1'b0;
    strobe_pulse(8'h21, 10, 10);
    strobe_pulse(8'h43, 10, 10);
    check("bp_valid", op_valid, 1'b1);
    check("bp_overrun0", overrun, 1'b0);
    strobe_pulse(8'h99, 10, 10);
    check("bp_overrun1", overrun, 1'b1);
    check("bp_op_a", op_a, 8'h21);
    check("bp_op_b", op_b, 8'h43);
    check("bp_still_valid", op_valid, 1'b1);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    check("bp_valid_drop", op_valid, 1'b0);
    check("bp_busy_drop", busy, 1'b0);
    check("bp_overrun_sticky", overrun, 1'b1);
    tick(3);
    check("bp_overrun_sticky2", overrun, 1'b1);

    // Asynchronous reset while a pair is pending: outputs clear before any edge.
    strobe_pulse(8'h5A, 10, 10);
    strobe_pulse(8'hC3, 10, 10);
    check("pre_rst_valid", op_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", op_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    check("arst_op_a", op_a, 8'h00);
    check("arst_op_b", op_b, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Clear after A, then reload.
    strobe_pulse(8'h11, 10, 10);
    check("clr_busy_before", busy, 1'b1);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    tick(4);
    check("clr_busy_after", busy, 1'b0);
    check("clr_op_a_kept", op_a, 8'h11);
    strobe_pulse(8'hAA, 10, 10);
    strobe_pulse(8'h55, 10, 10);
    check("reload_op_a", op_a, 8'hAA);
    check("reload_op_b", op_b, 8'h55);
    check("reload_valid", op_valid, 1'b1);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    // Clear lands in the same cycle as the strobe event.
    data_in   = 8'h3C;
    strobe_in = 1'b1;
    tick(4);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    tick(6);
    strobe_in = 1'b0;
    tick(10);
    check("clr_evt_busy", busy, 1'b0);
    check("clr_evt_op_a", op_a, 8'hAA);

    // Handshake and event in the same cycle.
    strobe_pulse(8'h01, 10, 10);
    strobe_pulse(8'h02, 10, 10);
    check("hs_evt_pre_valid", op_valid, 1'b1);
    data_in   = 8'h03;
    strobe_in = 1'b1;
    tick(6);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    check("hs_evt_valid", op_valid, 1'b0);
    check("hs_evt_busy", busy, 1'b0);
    check("hs_evt_overrun", overrun, 1'b1);
    check("hs_evt_op_a", op_a, 8'h01);
    check("hs_evt_op_b", op_b, 8'h02);
    tick(3);
    strobe_in = 1'b0;
    tick(10);
    check("hs_evt_no_capture", busy, 1'b0);

    // Randomized operation sequence against the transaction model.
    m_held = 0;
    m_a    = 8'h01;
    m_b    = 8'h02;
    m_ovr  = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int         kind;
      logic [7:0] d;
      kind = int'($urandom_range(0, 5));
      d    = 8'($urandom);
      case (kind)
        0, 1, 2: begin
          strobe_pulse(d, int'($urandom_range(8, 12)), int'($urandom_range(8, 12)));
          model_strobe(d);
        end
        3: begin
          strobe_pulse(d, int'($urandom_range(1, 3)), 8);
        end
        4: begin
          op_ready = 1'b1;
          tick(1);
          op_ready = 1'b0;
          tick(2);
          if (m_held == 2) m_held = 0;
        end
        default: begin
          clear_in = 1'b1;
          tick(1);
          clear_in = 1'b0;
          tick(4);
          m_held = 0;
          m_ovr  = 1'b0;
        end
      endcase
      check("rnd_op_a", op_a, m_a);
      if (m_held == 2) check("rnd_op_b", op_b, m_b);
      check("rnd_valid", op_valid, (m_held == 2));
      check("rnd_busy", busy, (m_held != 0));
      check("rnd_overrun", overrun, m_ovr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
